// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester round-robin output arbiter.
package mux_arb_pkg;

  localparam int HOLD_W = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD0 = 2'd1;
  localparam logic [1:0] HOLD1 = 2'd2;

endpackage

// File: rtl/mux2to1_w.sv
// DATA_W-wide 2:1 multiplexer; sel = 1 picks b.
module mux2to1_w #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester arbiter with hold-limited round robin feeding one registered output word.
//   state | meaning
//   IDLE  | output register empty
//   HOLD0 | output holds a word from requester 0
//   HOLD1 | output holds a word from requester 1
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_sel
);

  localparam logic [HOLD_W-1:0] max_hold_c = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] one_c      = HOLD_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              last_win;
  logic              can_accept;
  logic              grant_any;
  logic              gnt;
  logic              keep;
  logic [DATA_W-1:0] mux_y;

  // hold_cnt == 0 means no grant since reset, so the first tie goes to ~last_win (requester 0).
  assign keep       = (hold_cnt != '0) && (hold_cnt < max_hold_c);
  assign can_accept = rst_n && ((state == IDLE) || out_ready);
  assign grant_any  = can_accept && (req0_valid || req1_valid);

  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = keep ? last_win : ~last_win;
    end else if (req1_valid) begin
      gnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (grant_any) begin
      state_nxt = gnt ? HOLD1 : HOLD0;
    end else if ((state != IDLE) && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    out_valid  = (state != IDLE);
    req0_ready = grant_any && !gnt;
    req1_ready = grant_any && gnt;
  end

  mux2to1_w #(.DATA_W(DATA_W)) u_mux (
    .sel (gnt),
    .a   (req0_data),
    .b   (req1_data),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 1'b0;
      hold_cnt <= '0;
      last_win <= 1'b1;
    end else if (grant_any) begin
      out_data <= mux_y;
      out_sel  <= gnt;
      last_win <= gnt;
      if (gnt != last_win) begin
        hold_cnt <= one_c;
      end else if (hold_cnt < max_hold_c) begin
        hold_cnt <= hold_cnt + one_c;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed stimulus pushes expected words, a monitor pops on drain.
module tb_mux2_rr_arbiter;

  typedef struct packed {
    logic       sel;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_sel;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_sel    (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; er0/er1 are the hand-computed readies for this cycle.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                      input logic ordy, input logic er0, input logic er1, input string tag);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    @(negedge clk);
    chk({tag, " req0_ready"}, 32'(req0_ready), 32'(er0));
    chk({tag, " req1_ready"}, 32'(req1_ready), 32'(er1));
    if (er0) sbq.push_back(exp_t'{sel: 1'b0, data: d0});
    if (er1) sbq.push_back(exp_t'{sel: 1'b1, data: d1});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got sel=%0d data=0x%0h, expected no word", out_sel, out_data);
      end else begin
        e = sbq.pop_front();
        chk("sb out_sel", 32'(out_sel), 32'(e.sel));
        chk("sb out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  localparam logic [8:0] tie_seq = 9'b0_1111_0000; // bit i = expected winner of tie cycle i

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;

    // readies stay low while in reset even with both requesters valid
    step(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, "rst");
    sbq.delete();
    rst_n = 1'b1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_sel", 32'(out_sel), 0);
    chk("rst hold_cnt", 32'(dut.hold_cnt), 0);

    // single requester 0
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "single0");
    chk("single0 out_valid", 32'(out_valid), 1);
    chk("single0 out_data", 32'(out_data), 32'h11);
    chk("single0 out_sel", 32'(out_sel), 0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "single0 drain");
    chk("drain out_valid", 32'(out_valid), 0);
    chk("drain out_data kept", 32'(out_data), 32'h11);

    // fresh reset so the first tie sees the reset arbitration history
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst2");
    sbq.delete();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1,
           !tie_seq[i], tie_seq[i], $sformatf("tie%0d", i));
      if (i == 0) begin
        chk("tie0 out_data", 32'(out_data), 32'hA0);
        chk("tie0 out_sel", 32'(out_sel), 0);
      end
      chk($sformatf("tie%0d out_valid", i), 32'(out_valid), 1);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "tie drain");

    // stall while holding 0x5C, requester 1 waiting
    step(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "stall load");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, $sformatf("stall%0d", i));
      chk($sformatf("stall%0d out_data", i), 32'(out_data), 32'h5C);
      chk($sformatf("stall%0d out_sel", i), 32'(out_sel), 0);
      chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 1);
    end
    step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, "stall release");
    chk("release out_data", 32'(out_data), 32'h77);
    chk("release out_sel", 32'(out_sel), 1);

    // reset while in HOLD1 discards the held word
    rst_n = 1'b0;
    step(1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, "rst mid");
    sbq.delete();
    rst_n = 1'b1;
    chk("rst mid out_valid", 32'(out_valid), 0);
    chk("rst mid out_data", 32'(out_data), 0);
    chk("rst mid out_sel", 32'(out_sel), 0);
    chk("rst mid hold_cnt", 32'(dut.hold_cnt), 0);

    // single word from requester 1, then nothing
    step(1'b0, 8'h00, 1'b1, 8'h3D, 1'b1, 1'b0, 1'b1, "single1");
    chk("single1 out_valid", 32'(out_valid), 1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "single1 drain");
    chk("single1 idle out_valid", 32'(out_valid), 0);
    chk("single1 idle out_data", 32'(out_data), 32'h3D);
    chk("single1 idle out_sel", 32'(out_sel), 1);

    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "tail");
    chk("sb leftover words", 32'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester data word and of the output word.
REQ-002 Parameter MAX_HOLD, default 4, range 1..15, maximum consecutive grants to one requester while the other is waiting.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port req0_valid, input, 1, requester 0 offers a word.
REQ-006 Port req0_data, input, DATA_W, requester 0 word.
REQ-007 Port req0_ready, output, 1, requester 0 word accepted this cycle when high together with req0_valid.
REQ-008 Ports req1_valid / req1_data / req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 Port out_valid, output, 1, output register holds a word.
REQ-010 Port out_data, output, DATA_W, registered output word.
REQ-011 Port out_ready, input, 1, downstream consumes the word when high together with out_valid.
REQ-012 Port out_sel, output, 1, index of the requester that produced the word in out_data.

Function
REQ-013 The FSM SHALL have three states: IDLE (output empty), HOLD0 (output holds a word from requester 0), HOLD1 (output holds a word from requester 1); out_valid = (state != IDLE).
REQ-014 can_accept SHALL be (state == IDLE) or out_ready; no word is accepted when can_accept is low.
REQ-015 When can_accept is high and exactly one requester is valid, that requester SHALL be granted.
REQ-016 When both are valid, the last winner SHALL be granted if hold_cnt < MAX_HOLD; otherwise the other requester SHALL be granted.
REQ-017 reqN_ready SHALL be high only when can_accept is high and requester N is granted; at most one ready is high per cycle; ready is combinational from state, hold_cnt, last winner, valids and out_ready.
REQ-018 On a grant to N, the next cycle SHALL have state HOLDN, out_data = reqN_data as sampled, out_sel = N; latency is one cycle from accept to out_valid.
REQ-019 When the output drains (out_valid and out_ready) with no new grant, the next state SHALL be IDLE; out_data and out_sel retain their last values.
REQ-020 Simultaneous drain and grant SHALL load the new word with no bubble, giving one word per cycle sustained.
REQ-021 hold_cnt (4 bits) SHALL be set to 1 on a grant to a requester different from the last winner, incremented on a grant to the same winner, and saturate at MAX_HOLD.
REQ-022 While out_valid is high and out_ready is low, out_data, out_sel and the state SHALL be stable.
REQ-023 A requester dropping valid before it is granted SHALL have no effect on the arbiter state.

Reset
REQ-024 While rst_n is low at a clock edge: state = IDLE, out_data = 0, out_sel = 0, hold_cnt = 0, last winner = 1 (requester 0 wins the first tie); both readies SHALL be low during reset.
REQ-025 Reset asserted mid-transfer SHALL discard the held word; no handshake completes in the reset cycle.

Structure
REQ-026 A shared package mux_arb_pkg SHALL hold the FSM state encoding constants (IDLE = 2'd0, HOLD0 = 2'd1, HOLD1 = 2'd2) and the hold-counter width.
REQ-027 The datapath select SHALL be one sub-module, mux2to1_w (DATA_W-wide 2:1 mux), driven by the grant index; all control SHALL stay in mux2_rr_arbiter.

Verification
REQ-028 Only req0 valid with data 0x11, out_ready = 1 -> req0_ready = 1; next cycle out_valid = 1, out_data = 0x11, out_sel = 0.
REQ-029 First tie after reset, both valid (0xA0 / 0xB0), out_ready = 1 -> req0 is granted first; 0xA0 appears with out_sel = 0.
REQ-030 Both valid continuously, MAX_HOLD = 4, out_ready = 1 -> out_sel sequence 0,0,0,0,1,1,1,1,0 with one word per cycle.
REQ-031 out_ready = 0 for 3 cycles while holding 0x5C -> out_data = 0x5C stable, both readies low; draining on the 4th cycle with req1 valid loads req1's word the next cycle.
REQ-032 rst_n = 0 for one edge while in HOLD1 -> next cycle out_valid = 0, out_data = 0, out_sel = 0, hold_cnt = 0.
REQ-033 A single word then no requests, out_ready = 1 -> out_valid for exactly one cycle, then IDLE with out_data retained.
